// File: rtl/hazard_stall_controller_pkg.sv
// ============================================================================
// Module : hazard_stall_controller_pkg
// Brief  : Shared types for the hazard/stall controller: shadow pipeline
//          entry layout, memory FSM state encoding and the source-match helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_stall_controller_pkg;

    // Register address width used by the shadow entries.
    localparam int CORE_REG_W = 4;

    // Destination info tracked for each of EXE, MEM and WB.
    typedef struct packed {
        logic                  vld;
        logic                  wb_en;
        logic [CORE_REG_W-1:0] dst;
        logic                  mem_rd;
        logic                  mem_wr;
    } shadow_entry_t;

    localparam shadow_entry_t SHADOW_EMPTY = '0;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

    // A source depends on an entry only if that entry really writes it.
    function automatic logic src_match(input shadow_entry_t e,
                                       input logic [CORE_REG_W-1:0] src);
        return e.vld & e.wb_en & (e.dst == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_controller_if.sv
// ============================================================================
// Module : hazard_stall_controller_if
// Brief  : SRAM request/ready handshake between the MEM-stage sequencer
//          (master) and the SRAM (slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_stall_controller_if;

    logic mem_req;     // level request, held until ready or timeout
    logic mem_ready;   // SRAM completes the current access
    logic mem_err;     // one-cycle pulse on abandoned access

    modport master (output mem_req, output mem_err, input mem_ready);
    modport slave  (input mem_req, input mem_err, output mem_ready);

endinterface

`default_nettype wire

// File: rtl/hazard_stall_controller_mem_access_fsm.sv
// ============================================================================
// Module : mem_access_fsm
// Brief  : Sequences one SRAM access for the MEM stage: holds mem_req and the
//          pipeline freeze until mem_ready or timeout, then releases the pipe
//          for a single DONE cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_fsm
    import hazard_stall_controller_pkg::*;
#(
    parameter int MEM_TMO = 255
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic start,      // a memory op lands in MEM on this edge
    input  wire logic mem_ready,
    output logic      mem_req,
    output logic      mem_err,
    output logic      freeze
);

    localparam int TMO_W = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

    mem_state_t       state;
    logic [TMO_W-1:0] tmo_cnt;

    // Access sequencer; every output is registered so reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MEM_IDLE;
            tmo_cnt <= '0;
            mem_req <= 1'b0;
            mem_err <= 1'b0;
            freeze  <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            unique case (state)
                // DONE behaves like IDLE so a back-to-back op starts right away.
                MEM_IDLE, MEM_DONE: begin
                    if (start) begin
                        state   <= MEM_ACCESS;
                        tmo_cnt <= '0;
                        mem_req <= 1'b1;
                        freeze  <= 1'b1;
                    end else begin
                        state   <= MEM_IDLE;
                    end
                end
                MEM_ACCESS: begin
                    if (mem_ready) begin
                        state   <= MEM_DONE;
                        mem_req <= 1'b0;
                        freeze  <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= MEM_DONE;
                        mem_req <= 1'b0;
                        freeze  <= 1'b0;
                        mem_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    state   <= MEM_IDLE;
                    mem_req <= 1'b0;
                    freeze  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module : hazard_stall_controller
// Brief  : Data-hazard stall, branch flush and SRAM freeze sequencing for the
//          5-stage pipeline, using a private shadow of EXE/MEM/WB destinations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    // Must equal CORE_REG_W: the shadow entries are sized by the package.
    parameter int REG_W   = CORE_REG_W,
    parameter int PERF_W  = 16,
    parameter int MEM_TMO = 255
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             forward_en,
    input  wire logic             id_valid,
    input  wire logic [REG_W-1:0] id_src1,
    input  wire logic [REG_W-1:0] id_src2,
    input  wire logic             id_two_src,
    input  wire logic             id_wb_en,
    input  wire logic [REG_W-1:0] id_dst,
    input  wire logic             id_mem_rd,
    input  wire logic             id_mem_wr,
    input  wire logic             branch_taken,
    hazard_stall_controller_if.master mem_bus,
    output logic                  hazard_stall,
    output logic                  pipe_freeze,
    output logic                  id_flush,
    output logic [PERF_W-1:0]     stall_cnt,
    output logic [PERF_W-1:0]     freeze_cnt
);

    shadow_entry_t exe_q;
    shadow_entry_t mem_q;
    shadow_entry_t wb_q;
    shadow_entry_t id_entry;
    logic          branch_pend;
    logic          hit_exe;
    logic          hit_mem;
    logic          raw_hazard;
    logic          start;

    // WB is kept for completeness of the shadow but never creates a hazard
    // (register file is write-first), and MEM's access type is consumed when
    // the op lands there, so these bits have no reader.
    logic shadow_unused;
    assign shadow_unused = ^{wb_q, mem_q.mem_rd, mem_q.mem_wr};

    // Hazard detection and branch flush; a flush always wins over a stall.
    always_comb begin
        id_entry        = SHADOW_EMPTY;
        id_entry.vld    = 1'b1;
        id_entry.wb_en  = id_wb_en;
        id_entry.dst    = id_dst;
        id_entry.mem_rd = id_mem_rd;
        id_entry.mem_wr = id_mem_wr;

        hit_exe = src_match(exe_q, id_src1) | (id_two_src & src_match(exe_q, id_src2));
        hit_mem = src_match(mem_q, id_src1) | (id_two_src & src_match(mem_q, id_src2));

        if (forward_en) begin
            raw_hazard = hit_exe & exe_q.mem_rd;
        end else begin
            raw_hazard = hit_exe | hit_mem;
        end

        id_flush     = branch_taken | branch_pend;
        hazard_stall = id_valid & raw_hazard & ~id_flush;
    end

    // The access is launched on the same edge the op enters MEM, so the
    // freeze covers its very first cycle there.
    assign start = ~pipe_freeze & exe_q.vld & (exe_q.mem_rd | exe_q.mem_wr);

    // Shadow pipe shift, and capture of branches that arrive during a freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q       <= SHADOW_EMPTY;
            mem_q       <= SHADOW_EMPTY;
            wb_q        <= SHADOW_EMPTY;
            branch_pend <= 1'b0;
        end else if (!pipe_freeze) begin
            wb_q        <= mem_q;
            mem_q       <= exe_q;
            exe_q       <= (id_valid & ~hazard_stall & ~id_flush) ? id_entry : SHADOW_EMPTY;
            branch_pend <= 1'b0;
        end else if (branch_taken) begin
            branch_pend <= 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (hazard_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
            if (pipe_freeze && (freeze_cnt != '1)) begin
                freeze_cnt <= freeze_cnt + PERF_W'(1);
            end
        end
    end

    mem_access_fsm #(
        .MEM_TMO (MEM_TMO)
    ) u_mem_access_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_ready (mem_bus.mem_ready),
        .mem_req   (mem_bus.mem_req),
        .mem_err   (mem_bus.mem_err),
        .freeze    (pipe_freeze)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module : tb_hazard_stall_controller
// Brief  : Self-checking bench for hazard_stall_controller: hazard table,
//          directed memory/branch/reset sequences, and randomized traffic
//          checked against an instruction-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

    localparam int REG_W   = 4;
    localparam int PERF_W  = 8;
    localparam int MEM_TMO = 255;
    localparam int SAT     = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              forward_en = 1'b0;
    logic              id_valid = 1'b0;
    logic [REG_W-1:0]  id_src1 = '0;
    logic [REG_W-1:0]  id_src2 = '0;
    logic              id_two_src = 1'b0;
    logic              id_wb_en = 1'b0;
    logic [REG_W-1:0]  id_dst = '0;
    logic              id_mem_rd = 1'b0;
    logic              id_mem_wr = 1'b0;
    logic              branch_taken = 1'b0;
    logic              hazard_stall;
    logic              pipe_freeze;
    logic              id_flush;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] freeze_cnt;

    hazard_stall_controller_if mem_bus();

    hazard_stall_controller #(
        .REG_W   (REG_W),
        .PERF_W  (PERF_W),
        .MEM_TMO (MEM_TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .forward_en   (forward_en),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_wb_en     (id_wb_en),
        .id_dst       (id_dst),
        .id_mem_rd    (id_mem_rd),
        .id_mem_wr    (id_mem_wr),
        .branch_taken (branch_taken),
        .mem_bus      (mem_bus),
        .hazard_stall (hazard_stall),
        .pipe_freeze  (pipe_freeze),
        .id_flush     (id_flush),
        .stall_cnt    (stall_cnt),
        .freeze_cnt   (freeze_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ------------------------------------------------------------------
    // Reference model: instructions in flight plus "is an SRAM access
    // outstanding, and for how long".
    // ------------------------------------------------------------------
    typedef struct {
        bit vld;
        bit wb;
        bit rd;
        bit wr;
        int dst;
    } ins_t;

    ins_t m_exe;
    ins_t m_mem;
    bit   m_acc;
    bit   m_err;
    bit   m_bpend;
    int   m_age;
    int   m_scnt;
    int   m_fcnt;

    task automatic model_reset();
        m_exe   = '{0, 0, 0, 0, 0};
        m_mem   = '{0, 0, 0, 0, 0};
        m_acc   = 0;
        m_err   = 0;
        m_bpend = 0;
        m_age   = 0;
        m_scnt  = 0;
        m_fcnt  = 0;
    endtask

    function automatic bit reads_from(ins_t e);
        return e.vld && e.wb &&
               (e.dst == int'(id_src1) || (id_two_src && e.dst == int'(id_src2)));
    endfunction

    function automatic bit exp_flush();
        return branch_taken || m_bpend;
    endfunction

    function automatic bit exp_stall();
        bit h;
        if (forward_en) h = reads_from(m_exe) && m_exe.rd;
        else            h = reads_from(m_exe) || reads_from(m_mem);
        return id_valid && h && !exp_flush();
    endfunction

    task automatic model_update();
        bit fr;
        bit st;
        bit fl;
        bit launch;
        fr = m_acc;
        st = exp_stall();
        fl = exp_flush();
        launch = m_exe.vld && (m_exe.rd || m_exe.wr);
        if (st && m_scnt < SAT) m_scnt++;
        if (fr && m_fcnt < SAT) m_fcnt++;
        if (fr) begin
            m_age++;
            if (mem_bus.mem_ready) begin
                m_acc = 0;
            end else if (m_age == MEM_TMO) begin
                m_acc = 0;
                m_err = 1;
            end
            if (branch_taken) m_bpend = 1;
        end else begin
            m_err   = 0;
            m_bpend = 0;
            if (launch) begin
                m_acc = 1;
                m_age = 0;
            end
            m_mem     = m_exe;
            m_exe.vld = id_valid && !st && !fl;
            m_exe.wb  = id_wb_en;
            m_exe.dst = int'(id_dst);
            m_exe.rd  = id_mem_rd;
            m_exe.wr  = id_mem_wr;
        end
    endtask

    // ------------------------------------------------------------------
    // Checking and stepping
    // ------------------------------------------------------------------
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check("hazard_stall", int'(hazard_stall), int'(exp_stall()));
        check("id_flush", int'(id_flush), int'(exp_flush()));
        check("pipe_freeze", int'(pipe_freeze), int'(m_acc));
        check("mem_req", int'(mem_bus.mem_req), int'(m_acc));
        check("mem_err", int'(mem_bus.mem_err), int'(m_err));
        check("stall_cnt", int'(stall_cnt), m_scnt);
        check("freeze_cnt", int'(freeze_cnt), m_fcnt);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic set_id(input bit v, input int s1, input int s2, input bit two,
                          input bit wb, input int dst, input bit rd, input bit wr);
        id_valid   = v;
        id_src1    = REG_W'(s1);
        id_src2    = REG_W'(s2);
        id_two_src = two;
        id_wb_en   = wb;
        id_dst     = REG_W'(dst);
        id_mem_rd  = rd;
        id_mem_wr  = wr;
    endtask

    task automatic drain();
        int n;
        n = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        branch_taken      = 0;
        mem_bus.mem_ready = 1;
        while ((m_acc || m_err || m_exe.vld || m_mem.vld) && n < 20) begin
            step();
            n++;
        end
        check("drain_bound", n < 20 ? 1 : 0, 1);
    endtask

    // ------------------------------------------------------------------
    // Hazard vectors: EXE and MEM contents, ID instruction, expectations
    // ------------------------------------------------------------------
    typedef struct {
        bit fwd;
        bit e_wb; int e_dst; bit e_rd;
        bit m_wb; int m_dst;
        int s1; int s2; bit two;
        bit br;
        bit x_stall; bit x_flush;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    initial begin
        #10000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fcount;
        int req_n;
        int err_n;
        int last_req;
        int err_at;
        int n;

        tbl[0]  = '{1, 1,3,1, 0,0, 3,2,1, 0, 1,0};   // load-use on src1
        tbl[1]  = '{1, 1,3,0, 0,0, 3,2,1, 0, 0,0};   // ALU result forwarded
        tbl[2]  = '{0, 1,3,0, 0,0, 3,2,1, 0, 1,0};   // no forwarding, EXE hit
        tbl[3]  = '{0, 0,5,0, 1,6, 6,1,0, 0, 1,0};   // no forwarding, MEM hit
        tbl[4]  = '{0, 1,5,0, 1,6, 7,7,1, 0, 0,0};   // no dependence
        tbl[5]  = '{0, 1,5,0, 1,6, 1,6,0, 0, 0,0};   // src2 not read
        tbl[6]  = '{0, 1,5,0, 1,6, 1,6,1, 0, 1,0};   // src2 read, MEM hit
        tbl[7]  = '{1, 1,4,1, 0,0, 0,4,1, 1, 0,1};   // branch overrides load-use
        tbl[8]  = '{1, 0,9,0, 1,6, 6,0,0, 0, 0,0};   // MEM hit forwarded
        tbl[9]  = '{0, 0,5,1, 0,0, 5,0,0, 0, 0,0};   // EXE does not write
        tbl[10] = '{1, 1,2,1, 0,0, 0,2,1, 0, 1,0};   // load-use on src2

        // Reset state
        model_reset();
        mem_bus.mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_mem_req", int'(mem_bus.mem_req), 0);
        check("reset_freeze", int'(pipe_freeze), 0);
        check("reset_mem_err", int'(mem_bus.mem_err), 0);
        check("reset_stall_cnt", int'(stall_cnt), 0);
        check("reset_freeze_cnt", int'(freeze_cnt), 0);
        rst_n = 1;

        // Load-use with forwarding: one stall cycle, then EXE holds a bubble
        forward_en        = 1;
        mem_bus.mem_ready = 1;
        set_id(1, 15, 15, 0, 1, 3, 1, 0);            // LDR r3
        step();
        set_id(1, 3, 2, 1, 1, 1, 0, 0);              // ADD r1, r3, r2
        sample();
        check("ldr_use_stall", int'(hazard_stall), 1);
        advance();
        sample();
        check("ldr_use_released", int'(hazard_stall), 0);
        check("ldr_use_stall_cnt", int'(stall_cnt), 1);
        advance();

        // Hazard table
        for (int k = 0; k < NV; k++) begin
            drain();
            forward_en = tbl[k].fwd;
            set_id(1, 15, 15, 0, tbl[k].m_wb, tbl[k].m_dst, 0, 0);
            step();
            set_id(1, 15, 15, 0, tbl[k].e_wb, tbl[k].e_dst, tbl[k].e_rd, 0);
            step();
            set_id(1, tbl[k].s1, tbl[k].s2, tbl[k].two, 0, 0, 0, 0);
            branch_taken = tbl[k].br;
            sample();
            check($sformatf("vec%0d_stall", k), int'(hazard_stall), int'(tbl[k].x_stall));
            check($sformatf("vec%0d_flush", k), int'(id_flush), int'(tbl[k].x_flush));
            advance();
            branch_taken = 0;
        end

        // Load waiting 4 cycles on mem_ready: exactly 4 frozen cycles
        drain();
        mem_bus.mem_ready = 0;
        set_id(1, 15, 15, 0, 1, 2, 1, 0);            // LDR r2
        step();
        set_id(1, 15, 15, 0, 1, 9, 0, 0);            // younger ALU op held in ID
        fcount = 0;
        for (int i = 0; i < 20; i++) begin
            mem_bus.mem_ready = (m_acc && m_age == 3);
            sample();
            if (pipe_freeze) fcount++;
            advance();
        end
        check("ldr_freeze_len", fcount, 4);

        // SRAM never answers: request held MEM_TMO cycles, error right after
        drain();
        mem_bus.mem_ready = 0;
        set_id(1, 15, 15, 0, 0, 0, 0, 1);            // STR
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        req_n = 0; err_n = 0; last_req = -1; err_at = -1;
        for (int i = 0; i < 300; i++) begin
            sample();
            if (mem_bus.mem_req) begin req_n++; last_req = i; end
            if (mem_bus.mem_err) begin err_n++; err_at = i; end
            advance();
        end
        check("tmo_req_cycles", req_n, MEM_TMO);
        check("tmo_err_pulses", err_n, 1);
        check("tmo_err_after_req", err_at, last_req + 1);

        // Taken branch over a load-use hazard: flush wins, EXE gets a bubble
        drain();
        forward_en = 1;
        set_id(1, 15, 15, 0, 1, 4, 1, 0);            // LDR r4
        step();
        set_id(1, 4, 15, 0, 1, 8, 0, 0);             // reads r4, writes r8
        branch_taken = 1;
        sample();
        check("flush_over_stall", int'(hazard_stall), 0);
        check("flush_asserted", int'(id_flush), 1);
        advance();
        branch_taken = 0;
        forward_en   = 0;
        set_id(1, 8, 15, 0, 0, 0, 0, 0);             // would hit a non-flushed r8
        sample();
        check("flushed_exe_bubble", int'(hazard_stall), 0);
        advance();

        // Asynchronous reset in the middle of an access
        drain();
        mem_bus.mem_ready = 0;
        set_id(1, 15, 15, 0, 1, 1, 1, 0);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (!m_acc && n < 10) begin step(); n++; end
        step();
        check("rst_pre_access", int'(mem_bus.mem_req), 1);
        #3;
        rst_n = 0;
        #1;
        check("rst_mem_req", int'(mem_bus.mem_req), 0);
        check("rst_freeze", int'(pipe_freeze), 0);
        check("rst_stall_cnt", int'(stall_cnt), 0);
        check("rst_freeze_cnt", int'(freeze_cnt), 0);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
        step();
        step();

        // Randomized traffic against the model
        mem_bus.mem_ready = 1;
        for (int i = 0; i < 2500; i++) begin
            int op;
            if ($urandom_range(0, 15) == 0) forward_en = !forward_en;
            op = $urandom_range(0, 7);
            set_id($urandom_range(0, 3) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), op == 0, op == 1);
            branch_taken      = ($urandom_range(0, 7) == 0);
            mem_bus.mem_ready = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
